if_id_skid_stage: RTL and testbench
===================================

Name: if_id_skid_stage

Overview:
- Parametrised fetch-to-decode pipeline stage. It carries brBaseOffset, pcIncremented, instWord and prediction.
- It replaces the plain write-enabled stage register with a valid/ready handshake and a 2-entry skid buffer. The fetch side therefore sees a registered ready, and decode back-pressure never drops an instruction.
- A flush input squashes all in-flight entries on branch mispredict.
- While the stage is empty, it presents a configurable NOP to decode.

Parameters:
- DBITS, 32, width of brBaseOffset, pcIncremented and instWord.
- NOP_WORD, 32'h0000_0000, instWord value driven on out_instWord whenever out_valid=0 (DBITS wide).
- RESET_PC, 0, value of out_pcIncremented and entry pc fields after reset.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous active-low reset; 0 clears the stage immediately.
- flush  input  1  squash all entries; has priority over all other events.
- in_valid  input  1  fetch presents a valid instruction.
- in_ready  output  1  stage can accept; registered, equals !skid_valid.
- in_brBaseOffset  input  DBITS  branch target from fetch.
- in_pcIncremented  input  DBITS  PC+4 from fetch.
- in_instWord  input  DBITS  fetched instruction.
- in_prediction  input  1  branch predictor taken bit.
- out_valid  output  1  main entry holds a valid instruction.
- out_ready  input  1  decode consumes the main entry this cycle.
- out_brBaseOffset  output  DBITS  main entry field.
- out_pcIncremented  output  DBITS  main entry field.
- out_instWord  output  DBITS  main entry instWord when valid, NOP_WORD otherwise.
- out_prediction  output  1  main entry prediction when valid, 0 otherwise.
- occupancy  output  2  number of valid entries (0, 1 or 2).

Behaviour:
- Storage: a main entry (drives the outputs) and a skid entry. Each entry holds 3*DBITS+1 bits of data plus a valid bit. All storage is flops on clk.
- State is encoded by the valid bits: EMPTY (00), ONE (main only), FULL (main+skid). Skid valid without main valid is illegal and never reached.
- Accept = in_valid & in_ready. Consume = out_valid & out_ready.
- EMPTY:
  - accept -> ONE; main <= input.
- ONE:
  - accept & consume -> ONE; main <= input (single-cycle throughput).
  - accept & !consume -> FULL; skid <= input; main unchanged.
  - !accept & consume -> EMPTY.
  - otherwise hold.
- FULL: in_ready=0, so there is no accept.
  - consume -> ONE; main <= skid; skid invalid.
  - otherwise hold.
- Order is preserved: the skid entry is always younger than the main entry.
- flush=1 at a clock edge:
  - Both valid bits are cleared and next state is EMPTY, regardless of in_valid, out_ready or current state.
  - The input presented that cycle is dropped. in_ready that cycle still reflects current state, since it is registered.
  - Data fields need not be cleared.
- Latency: an accepted instruction appears on the outputs the cycle after acceptance when the stage was EMPTY, or ONE with consume.
- Output gating:
  - out_valid=0 forces out_instWord=NOP_WORD and out_prediction=0.
  - out_brBaseOffset and out_pcIncremented show the stale main data.
- occupancy = main_valid + skid_valid.
- in_ready = !skid_valid, taken directly from a flop with no combinational path from out_ready.
- Reset (reset=0, asynchronous):
  - Valid bits cleared.
  - Data fields: brBaseOffset=0, pcIncremented=RESET_PC, instWord=0, prediction=0.
  - Outputs: out_valid=0, in_ready=1, occupancy=0, out_instWord=NOP_WORD, out_pcIncremented=RESET_PC, out_brBaseOffset=0, out_prediction=0.
  - Reset asserted mid-operation discards all entries. The first edge after deassertion behaves as EMPTY.
- in_valid while in_ready=0 is legal; the input is ignored. Fetch must hold it until accepted.
- Data inputs are don't-care when in_valid=0.

Test Plan:
- Reset then idle: hold reset=0 for 3 cycles, release, all inputs 0 -> out_valid=0, in_ready=1, occupancy=0, out_instWord=NOP_WORD, out_pcIncremented=RESET_PC.
- Streaming: in_valid=1 with instWords 0x11,0x22,0x33 on consecutive cycles, out_ready=1 throughout -> out_instWord shows 0x11,0x22,0x33 one cycle later each, occupancy stays 1, in_ready stays 1.
- Back-pressure: send 0xA1 and 0xA2 with out_ready=0 -> occupancy=2 and in_ready=0 after the second edge. Hold 0xA3 on the input, then raise out_ready for 3 cycles -> decode sees 0xA1, 0xA2, 0xA3 in order with none lost or duplicated.
- Flush while FULL: occupancy=2, then flush=1 with in_valid=1, instWord=0xBB -> next cycle occupancy=0, out_valid=0, out_instWord=NOP_WORD, and 0xBB never appears.
- Async reset mid-stream: assert reset=0 between clock edges while occupancy=2 -> outputs go to reset values without waiting for a clock edge. After release, a new instWord 0xCC with out_ready=1 appears one cycle later.
- Prediction/field integrity: DBITS=16 build; send brBaseOffset=0xFFFF, pcIncremented=0x0004, instWord=0x1234, prediction=1 through a 2-cycle stall -> all four fields emerge intact. out_prediction=0 whenever out_valid=0.

Source files
------------

// File: rtl/if_id_skid_stage.sv
// Fetch-to-decode pipeline stage with a valid/ready handshake and a 2-entry skid buffer.
// in_ready comes straight from a flop, so decode back-pressure never forms a combinational path to fetch.
module if_id_skid_stage #(
  parameter int               DBITS    = 32,
  parameter logic [DBITS-1:0] NOP_WORD = '0,
  parameter logic [DBITS-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DBITS-1:0] in_brBaseOffset,
  input  logic [DBITS-1:0] in_pcIncremented,
  input  logic [DBITS-1:0] in_instWord,
  input  logic             in_prediction,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DBITS-1:0] out_brBaseOffset,
  output logic [DBITS-1:0] out_pcIncremented,
  output logic [DBITS-1:0] out_instWord,
  output logic             out_prediction,
  output logic [1:0]       occupancy
);

  typedef struct packed {
    logic [DBITS-1:0] br_base_offset;
    logic [DBITS-1:0] pc_incremented;
    logic [DBITS-1:0] inst_word;
    logic             prediction;
  } entry_t;

  // State bits are {skid_valid, main_valid}; 2'b10 is unreachable.
  typedef enum logic [1:0] {
    S_EMPTY = 2'b00,
    S_ONE   = 2'b01,
    S_FULL  = 2'b11
  } state_t;

  localparam entry_t RESET_ENTRY = '{
    br_base_offset: '0,
    pc_incremented: RESET_PC,
    inst_word:      '0,
    prediction:     1'b0
  };

  state_t state_q, state_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  entry_t in_entry;
  logic   accept;
  logic   consume;

  assign in_entry = '{in_brBaseOffset, in_pcIncremented, in_instWord, in_prediction};
  assign accept   = in_valid & in_ready;
  assign consume  = out_valid & out_ready;

  // NOTE: the entries are only two registers, so the data fields are reset along with the
  // valid bits; this gives defined outputs (RESET_PC, NOP) immediately after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_EMPTY;
      main_q  <= RESET_ENTRY;
      skid_q  <= RESET_ENTRY;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  always_comb begin
    // NOTE: hold-by-default assignments first, so no path through the case infers a latch.
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      S_EMPTY: begin
        if (accept) begin
          state_d = S_ONE;
          main_d  = in_entry;
        end
      end
      S_ONE: begin
        if (accept && consume) begin
          main_d = in_entry;
        end else if (accept) begin
          state_d = S_FULL;
          skid_d  = in_entry;
        end else if (consume) begin
          state_d = S_EMPTY;
        end
      end
      S_FULL: begin
        if (consume) begin
          state_d = S_ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = S_EMPTY;
    endcase
    // Flush wins over everything; stale data fields are harmless once the valid bits drop.
    if (flush) begin
      state_d = S_EMPTY;
    end
  end

  always_comb begin
    out_valid         = state_q[0];
    in_ready          = ~state_q[1];
    occupancy         = {1'b0, state_q[0]} + {1'b0, state_q[1]};
    out_brBaseOffset  = main_q.br_base_offset;
    out_pcIncremented = main_q.pc_incremented;
    out_instWord      = state_q[0] ? main_q.inst_word : NOP_WORD;
    out_prediction    = state_q[0] & main_q.prediction;
  end

endmodule

// File: tb/tb_if_id_skid_stage.sv
// Directed bench for if_id_skid_stage: a 32-bit build for handshake/flush/reset
// sequences and a 16-bit build for field integrity through a stall.
module tb_if_id_skid_stage;

  localparam logic [31:0] NOP_A = 32'h0000_0013;
  localparam logic [31:0] RPC_A = 32'h0000_1000;
  localparam logic [15:0] NOP_B = 16'hABCD;
  localparam logic [15:0] RPC_B = 16'h0100;

  logic clk = 1'b0;
  logic reset;

  logic        a_flush, a_in_valid, a_in_ready, a_in_pred, a_out_valid, a_out_ready, a_out_pred;
  logic [31:0] a_in_br, a_in_pc, a_in_inst, a_out_br, a_out_pc, a_out_inst;
  logic [1:0]  a_occ;

  logic        b_flush, b_in_valid, b_in_ready, b_in_pred, b_out_valid, b_out_ready, b_out_pred;
  logic [15:0] b_in_br, b_in_pc, b_in_inst, b_out_br, b_out_pc, b_out_inst;
  logic [1:0]  b_occ;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  if_id_skid_stage #(.DBITS(32), .NOP_WORD(NOP_A), .RESET_PC(RPC_A)) dut_a (
    .clk(clk), .reset(reset), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_brBaseOffset(a_in_br), .in_pcIncremented(a_in_pc),
    .in_instWord(a_in_inst), .in_prediction(a_in_pred),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_brBaseOffset(a_out_br), .out_pcIncremented(a_out_pc),
    .out_instWord(a_out_inst), .out_prediction(a_out_pred),
    .occupancy(a_occ)
  );

  if_id_skid_stage #(.DBITS(16), .NOP_WORD(NOP_B), .RESET_PC(RPC_B)) dut_b (
    .clk(clk), .reset(reset), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_brBaseOffset(b_in_br), .in_pcIncremented(b_in_pc),
    .in_instWord(b_in_inst), .in_prediction(b_in_pred),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_brBaseOffset(b_out_br), .out_pcIncremented(b_out_pc),
    .out_instWord(b_out_inst), .out_prediction(b_out_pred),
    .occupancy(b_occ)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [31:0] inst, input logic rdy);
    a_in_valid  = v;
    a_in_inst   = inst;
    a_in_br     = inst + 32'h100;
    a_in_pc     = inst + 32'h4;
    a_in_pred   = inst[0];
    a_out_ready = rdy;
  endtask

  task automatic check_idle_a(input string tag);
    check({tag, ".valid"}, {31'd0, a_out_valid}, 32'd0);
    check({tag, ".occ"},   {30'd0, a_occ},       32'd0);
    check({tag, ".ready"}, {31'd0, a_in_ready},  32'd1);
    check({tag, ".inst"},  a_out_inst,           NOP_A);
    check({tag, ".pred"},  {31'd0, a_out_pred},  32'd0);
  endtask

  task automatic check_main_a(input string tag, input logic [31:0] inst, input logic [1:0] occ);
    check({tag, ".valid"}, {31'd0, a_out_valid}, 32'd1);
    check({tag, ".occ"},   {30'd0, a_occ},       {30'd0, occ});
    check({tag, ".inst"},  a_out_inst,           inst);
    check({tag, ".br"},    a_out_br,             inst + 32'h100);
    check({tag, ".pc"},    a_out_pc,             inst + 32'h4);
    check({tag, ".pred"},  {31'd0, a_out_pred},  {31'd0, inst[0]});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    a_flush = 1'b0; drive_a(1'b0, 32'h0, 1'b0);
    b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0;
    b_in_br = '0; b_in_pc = '0; b_in_inst = '0; b_in_pred = 1'b0;

    // Reset held for 3 cycles
    repeat (3) @(posedge clk);
    #1;
    check_idle_a("rst");
    check("rst.pc", a_out_pc, RPC_A);
    check("rst.br", a_out_br, 32'd0);
    check("rst_b.pc",   {16'd0, b_out_pc},   {16'd0, RPC_B});
    check("rst_b.inst", {16'd0, b_out_inst}, {16'd0, NOP_B});
    reset = 1'b1;
    tick();
    check_idle_a("idle");
    check("idle.pc", a_out_pc, RPC_A);

    // 16-bit build: all fields survive a 2-cycle stall, prediction gated when invalid
    b_in_valid = 1'b1; b_in_br = 16'hFFFF; b_in_pc = 16'h0004; b_in_inst = 16'h1234; b_in_pred = 1'b1;
    tick();
    b_in_valid = 1'b0; b_in_br = '0; b_in_pc = '0; b_in_inst = '0; b_in_pred = 1'b0;
    tick();
    check("fld.valid", {31'd0, b_out_valid}, 32'd1);
    check("fld.br",    {16'd0, b_out_br},    32'h0000_FFFF);
    check("fld.pc",    {16'd0, b_out_pc},    32'h0000_0004);
    check("fld.inst",  {16'd0, b_out_inst},  32'h0000_1234);
    check("fld.pred",  {31'd0, b_out_pred},  32'd1);
    b_out_ready = 1'b1;
    tick();
    b_out_ready = 1'b0;
    check("fld_drain.valid", {31'd0, b_out_valid}, 32'd0);
    check("fld_drain.pred",  {31'd0, b_out_pred},  32'd0);
    check("fld_drain.inst",  {16'd0, b_out_inst},  {16'd0, NOP_B});
    check("fld_drain.br",    {16'd0, b_out_br},    32'h0000_FFFF);
    check("fld_drain.occ",   {30'd0, b_occ},       32'd0);

    // Streaming at full throughput
    drive_a(1'b1, 32'h11, 1'b1); tick(); check_main_a("s11", 32'h11, 2'd1);
    check("s11.ready", {31'd0, a_in_ready}, 32'd1);
    drive_a(1'b1, 32'h22, 1'b1); tick(); check_main_a("s22", 32'h22, 2'd1);
    check("s22.ready", {31'd0, a_in_ready}, 32'd1);
    drive_a(1'b1, 32'h33, 1'b1); tick(); check_main_a("s33", 32'h33, 2'd1);
    check("s33.ready", {31'd0, a_in_ready}, 32'd1);
    drive_a(1'b0, 32'h0, 1'b1);  tick(); check_idle_a("sdrain");
    check("sdrain.stale_pc", a_out_pc, 32'h37);

    // Back-pressure fills the skid, then drains in order while 0xA3 waits
    drive_a(1'b1, 32'hA1, 1'b0); tick(); check_main_a("bp1", 32'hA1, 2'd1);
    drive_a(1'b1, 32'hA2, 1'b0); tick(); check_main_a("bp2", 32'hA1, 2'd2);
    check("bp2.ready", {31'd0, a_in_ready}, 32'd0);
    drive_a(1'b1, 32'hA3, 1'b1); tick(); check_main_a("bpA2", 32'hA2, 2'd1);
    check("bpA2.ready", {31'd0, a_in_ready}, 32'd1);
    tick(); check_main_a("bpA3", 32'hA3, 2'd1);
    drive_a(1'b0, 32'h0, 1'b1);  tick(); check_idle_a("bpdrain");

    // Flush while FULL: the offered 0xBB is dropped
    drive_a(1'b1, 32'h51, 1'b0); tick();
    drive_a(1'b1, 32'h52, 1'b0); tick();
    check("fl.occ", {30'd0, a_occ}, 32'd2);
    drive_a(1'b1, 32'hBB, 1'b1); a_flush = 1'b1;
    check("fl.ready_pre", {31'd0, a_in_ready}, 32'd0);
    tick();
    a_flush = 1'b0; drive_a(1'b0, 32'h0, 1'b1);
    check_idle_a("fl");
    tick(); check_idle_a("fl_after");

    // Flush while ONE with an acceptable input: input still dropped
    drive_a(1'b1, 32'h71, 1'b0); tick(); check_main_a("fl1a", 32'h71, 2'd1);
    drive_a(1'b1, 32'hBD, 1'b0); a_flush = 1'b1; tick();
    a_flush = 1'b0; drive_a(1'b0, 32'h0, 1'b0);
    check_idle_a("fl1");
    tick(); check_idle_a("fl1_after");

    // Asynchronous reset while FULL, then a fresh instruction
    drive_a(1'b1, 32'h61, 1'b0); tick();
    drive_a(1'b1, 32'h62, 1'b0); tick();
    check("ar.occ", {30'd0, a_occ}, 32'd2);
    drive_a(1'b0, 32'h0, 1'b0);
    #2 reset = 1'b0;
    #1;
    check_idle_a("ar");
    check("ar.pc", a_out_pc, RPC_A);
    check("ar.br", a_out_br, 32'd0);
    #2 reset = 1'b1;
    drive_a(1'b1, 32'hCC, 1'b1); tick(); check_main_a("arCC", 32'hCC, 2'd1);
    drive_a(1'b0, 32'h0, 1'b1);  tick(); check_idle_a("ardrain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
